// File: rtl/lfp_e4m4_dot_accum_pkg.sv
// Shared E4M4 / Q6.11 definitions for the LFP multiplier-output consumers.
package lfp_e4m4_dot_accum_pkg;

    localparam int SIGN_W     = 1;
    localparam int EXP_W      = 4;
    localparam int MAN_W      = 4;
    localparam int E4M4_W     = SIGN_W + EXP_W + MAN_W;
    localparam int E4M4_BIAS  = 8;

    localparam int Q611_W     = 18;
    localparam int Q611_FRAC  = 11;
    localparam int Q611_MAX   = 131071;
    localparam int Q611_MIN   = -131072;

    localparam int TERM_W     = 21;

    typedef enum logic [1:0] {
        ST_ACC,
        ST_FLUSH,
        ST_OUT
    } state_e;

    typedef struct packed {
        logic                     sat;
        logic signed [Q611_W-1:0] data;
    } sat_res_t;

endpackage

// File: rtl/lfp_e4m4_dot_accum_if.sv
// Product stream in, Q6.11 result stream out; slave is the accumulator's view.
interface lfp_e4m4_dot_accum_if;

    logic                                              s_valid;
    logic                                              s_ready;
    logic [lfp_e4m4_dot_accum_pkg::E4M4_W-1:0]         s_data;
    logic                                              s_last;
    logic                                              m_valid;
    logic                                              m_ready;
    logic signed [lfp_e4m4_dot_accum_pkg::Q611_W-1:0]  m_data;
    logic                                              m_sat;

    modport slave (
        input  s_valid, s_data, s_last, m_ready,
        output s_ready, m_valid, m_data, m_sat
    );

    modport master (
        output s_valid, s_data, s_last, m_ready,
        input  s_ready, m_valid, m_data, m_sat
    );

endinterface

// File: rtl/e4m4_to_q_dec.sv
// Exact E4M4 -> Q6.11 decode: e=0 is zero, otherwise (16+m) << (e-1), signed.
module e4m4_to_q_dec
    import lfp_e4m4_dot_accum_pkg::*;
(
    input  logic [E4M4_W-1:0]        e4m4_i,
    output logic signed [TERM_W-1:0] term_o
);

    logic             sign;
    logic [EXP_W-1:0] expo;
    logic [MAN_W-1:0] man;
    logic [EXP_W-1:0] shamt;
    logic [TERM_W-1:0] mag;

    assign sign  = e4m4_i[E4M4_W-1];
    assign expo  = e4m4_i[MAN_W +: EXP_W];
    assign man   = e4m4_i[MAN_W-1:0];
    // Shift folds bias and fraction alignment: e - bias + frac - man_bits = e - 1.
    assign shamt = expo + EXP_W'(Q611_FRAC - MAN_W - E4M4_BIAS);

    always_comb begin
        mag = '0;
        if (expo != '0) begin
            mag = TERM_W'({1'b1, man}) << shamt;
        end
        term_o = sign ? -$signed(mag) : $signed(mag);
    end

endmodule

// File: rtl/lfp_e4m4_dot_accum.sv
// Frame-based E4M4 dot-product accumulator with a saturated Q6.11 handshaked result.
module lfp_e4m4_dot_accum
    import lfp_e4m4_dot_accum_pkg::*;
#(
    parameter int N_TERMS = 8,
    parameter int ACC_W   = 26
)(
    input  logic                 clk,
    input  logic                 rst_n,
    lfp_e4m4_dot_accum_if.slave  bus
);

    localparam int CNT_W = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;
    localparam logic [CNT_W-1:0]        CNT_LAST = CNT_W'(N_TERMS - 1);
    localparam logic signed [ACC_W-1:0] SAT_HI   = ACC_W'(Q611_MAX);
    localparam logic signed [ACC_W-1:0] SAT_LO   = ACC_W'(Q611_MIN);

    function automatic sat_res_t sat_q611(input logic signed [ACC_W-1:0] a);
        sat_res_t r;
        if (a > SAT_HI) begin
            r.sat  = 1'b1;
            r.data = Q611_W'(Q611_MAX);
        end else if (a < SAT_LO) begin
            r.sat  = 1'b1;
            r.data = Q611_W'(Q611_MIN);
        end else begin
            r.sat  = 1'b0;
            r.data = a[Q611_W-1:0];
        end
        return r;
    endfunction

    state_e                   state_q;
    logic                     s_ready_q;
    logic                     m_valid_q;
    logic                     m_sat_q;
    logic signed [Q611_W-1:0] m_data_q;
    logic [CNT_W-1:0]         cnt_q;
    logic signed [ACC_W-1:0]  acc_q;
    logic signed [ACC_W-1:0]  acc_d;
    logic signed [TERM_W-1:0] term_dec;
    logic signed [TERM_W-1:0] term_p1_q;
    logic                     vld_p1_q;
    logic                     last_p1_q;
    logic                     first_p1_q;
    logic                     last_p2_q;
    logic                     beat;
    logic                     close;
    sat_res_t                 sat_d;

    e4m4_to_q_dec u_dec (
        .e4m4_i (bus.s_data),
        .term_o (term_dec)
    );

    assign beat  = bus.s_valid & s_ready_q;
    assign close = bus.s_last | (cnt_q == CNT_LAST);

    always_comb begin
        acc_d = first_p1_q ? ACC_W'(term_p1_q) : acc_q + ACC_W'(term_p1_q);
    end

    assign sat_d = sat_q611(acc_q);

    // Stage 1: decoded term register
    always_ff @(posedge clk) begin
        if (beat) begin
            term_p1_q <= term_dec;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_ACC;
            s_ready_q  <= 1'b0;
            m_valid_q  <= 1'b0;
            m_data_q   <= '0;
            m_sat_q    <= 1'b0;
            cnt_q      <= '0;
            acc_q      <= '0;
            vld_p1_q   <= 1'b0;
            last_p1_q  <= 1'b0;
            first_p1_q <= 1'b0;
            last_p2_q  <= 1'b0;
        end else begin
            vld_p1_q   <= beat;
            last_p1_q  <= beat & close;
            first_p1_q <= beat & (cnt_q == '0);

            // Stage 2: accumulate; the first term of a frame loads
            last_p2_q  <= vld_p1_q & last_p1_q;
            if (vld_p1_q) begin
                acc_q <= acc_d;
            end

            case (state_q)
                ST_ACC: begin
                    s_ready_q <= 1'b1;
                    if (beat) begin
                        if (close) begin
                            s_ready_q <= 1'b0;
                            state_q   <= ST_FLUSH;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (last_p2_q) begin
                        m_data_q  <= sat_d.data;
                        m_sat_q   <= sat_d.sat;
                        m_valid_q <= 1'b1;
                        state_q   <= ST_OUT;
                    end
                end
                ST_OUT: begin
                    if (bus.m_ready) begin
                        m_valid_q <= 1'b0;
                        acc_q     <= '0;
                        cnt_q     <= '0;
                        s_ready_q <= 1'b1;
                        state_q   <= ST_ACC;
                    end
                end
                default: begin
                    state_q <= ST_ACC;
                end
            endcase
        end
    end

    assign bus.s_ready = s_ready_q;
    assign bus.m_valid = m_valid_q;
    assign bus.m_data  = m_data_q;
    assign bus.m_sat   = m_sat_q;

endmodule

// File: tb/tb_lfp_e4m4_dot_accum.sv
// Directed bench for the E4M4 dot-product accumulator: sums, saturation, handshakes, reset.
module tb_lfp_e4m4_dot_accum;

    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    logic [8:0] fq[$];

    always #5 clk = ~clk;

    lfp_e4m4_dot_accum_if bus ();

    lfp_e4m4_dot_accum #(.N_TERMS(8), .ACC_W(26)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Inputs change and outputs are sampled on the falling edge.
    task automatic send_beat(input logic [8:0] d, input logic last, input int gap);
        int n;
        repeat (gap) @(negedge clk);
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        bus.s_last  = last;
        n = 0;
        while (!bus.s_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 50) begin
            failures++;
            $display("FAIL beat_accept: s_ready never rose (waited %0d cycles, required < 50)", n);
        end
        @(negedge clk);
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
    endtask

    task automatic run_frame(input bit use_last, input bit gapped, output int lat,
                             output logic signed [17:0] d, output logic s, output int sr_bad);
        sr_bad = 0;
        for (int i = 0; i < fq.size(); i++) begin
            send_beat(fq[i], use_last && (i == fq.size() - 1), gapped ? (i % 3) : 0);
        end
        if (bus.s_ready) sr_bad++;
        lat = 0;
        while (!bus.m_valid && lat < 20) begin
            @(negedge clk);
            lat++;
            if (bus.s_ready) sr_bad++;
        end
        d = bus.m_data;
        s = bus.m_sat;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        bus.s_valid = 1'b0; bus.s_data = '0; bus.s_last = 1'b0; bus.m_ready = 1'b1;
        repeat (3) @(negedge clk);
        checks += 4;
        if (bus.s_ready !== 1'b0) begin failures++; $display("FAIL rst_s_ready: got %b want 0", bus.s_ready); end
        if (bus.m_valid !== 1'b0) begin failures++; $display("FAIL rst_m_valid: got %b want 0", bus.m_valid); end
        if (bus.m_data !== 18'sd0) begin failures++; $display("FAIL rst_m_data: got %0d want 0", bus.m_data); end
        if (bus.m_sat !== 1'b0) begin failures++; $display("FAIL rst_m_sat: got %b want 0", bus.m_sat); end
        rst_n = 1'b1;
        #1;
        checks++;
        if (bus.s_ready !== 1'b0) begin failures++; $display("FAIL rst_release_early: s_ready got %b want 0", bus.s_ready); end
        @(negedge clk);
        checks++;
        if (bus.s_ready !== 1'b1) begin failures++; $display("FAIL rst_release: s_ready got %b want 1", bus.s_ready); end
    endtask

    task automatic test_ones;
        int lat, srb; logic signed [17:0] d; logic s;
        fq = '{9'h080, 9'h080, 9'h080, 9'h080, 9'h080, 9'h080, 9'h080, 9'h080};
        run_frame(1'b0, 1'b0, lat, d, s, srb);
        checks += 4;
        if (lat !== 2) begin failures++; $display("FAIL ones_latency: got %0d want 2", lat); end
        if (d !== 18'sd16384) begin failures++; $display("FAIL ones_data: got %0d want 16384", d); end
        if (s !== 1'b0) begin failures++; $display("FAIL ones_sat: got %b want 0", s); end
        if (srb !== 0) begin failures++; $display("FAIL ones_s_ready_low: high on %0d cycles want 0", srb); end
        @(negedge clk);
        checks += 2;
        if (bus.m_valid !== 1'b0) begin failures++; $display("FAIL ones_consume: m_valid got %b want 0", bus.m_valid); end
        if (bus.s_ready !== 1'b1) begin failures++; $display("FAIL ones_reopen: s_ready got %b want 1", bus.s_ready); end
    endtask

    task automatic test_two_terms;
        int lat, srb; logic signed [17:0] d; logic s;
        fq = '{9'h088, 9'h170};
        run_frame(1'b1, 1'b0, lat, d, s, srb);
        checks += 4;
        if (lat !== 2) begin failures++; $display("FAIL two_latency: got %0d want 2", lat); end
        if (d !== 18'sd2048) begin failures++; $display("FAIL two_data: got %0d want 2048", d); end
        if (s !== 1'b0) begin failures++; $display("FAIL two_sat: got %b want 0", s); end
        if (srb !== 0) begin failures++; $display("FAIL two_s_ready_low: high on %0d cycles want 0", srb); end
        @(negedge clk);
        checks++;
        if (bus.s_ready !== 1'b1) begin failures++; $display("FAIL two_reopen: s_ready got %b want 1", bus.s_ready); end
    endtask

    task automatic test_saturation;
        int lat, srb; logic signed [17:0] d; logic s;
        fq = '{9'h0FF, 9'h0FF, 9'h0FF, 9'h0FF, 9'h0FF, 9'h0FF, 9'h0FF, 9'h0FF};
        run_frame(1'b0, 1'b0, lat, d, s, srb);
        checks += 2;
        if (d !== 18'sd131071) begin failures++; $display("FAIL sat_pos_data: got %0d want 131071", d); end
        if (s !== 1'b1) begin failures++; $display("FAIL sat_pos_flag: got %b want 1", s); end
        @(negedge clk);
        fq = '{9'h1FF, 9'h1FF, 9'h1FF, 9'h1FF, 9'h1FF, 9'h1FF, 9'h1FF, 9'h1FF};
        run_frame(1'b0, 1'b0, lat, d, s, srb);
        checks += 2;
        if (d !== -18'sd131072) begin failures++; $display("FAIL sat_neg_data: got %0d want -131072", d); end
        if (s !== 1'b1) begin failures++; $display("FAIL sat_neg_flag: got %b want 1", s); end
        @(negedge clk);
    endtask

    task automatic test_zero;
        int lat, srb; logic signed [17:0] d; logic s;
        fq = '{9'h10A, 9'h007, 9'h080};
        run_frame(1'b1, 1'b0, lat, d, s, srb);
        checks += 2;
        if (d !== 18'sd2048) begin failures++; $display("FAIL zero_data: got %0d want 2048", d); end
        if (s !== 1'b0) begin failures++; $display("FAIL zero_sat: got %b want 0", s); end
        @(negedge clk);
    endtask

    task automatic test_backpressure;
        int lat, srb, bad; logic signed [17:0] d; logic s;
        bus.m_ready = 1'b0;
        fq = '{9'h088, 9'h088, 9'h170};
        run_frame(1'b1, 1'b0, lat, d, s, srb);
        checks++;
        if (d !== 18'sd5120) begin failures++; $display("FAIL bp_data: got %0d want 5120", d); end
        bus.s_valid = 1'b1; bus.s_data = 9'h0FF; bus.s_last = 1'b1;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus.m_valid !== 1'b1 || bus.m_data !== 18'sd5120 || bus.m_sat !== 1'b0 || bus.s_ready !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin failures++; $display("FAIL bp_hold: %0d unstable cycles want 0 (last m_data=%0d)", bad, bus.m_data); end
        bus.s_valid = 1'b0; bus.s_last = 1'b0;
        bus.m_ready = 1'b1;
        @(negedge clk);
        checks += 2;
        if (bus.m_valid !== 1'b0) begin failures++; $display("FAIL bp_consume: m_valid got %b want 0", bus.m_valid); end
        if (bus.s_ready !== 1'b1) begin failures++; $display("FAIL bp_reopen: s_ready got %b want 1", bus.s_ready); end
    endtask

    task automatic test_gaps;
        int lat, srb; logic signed [17:0] d0, d1; logic s0, s1;
        fq = '{9'h088, 9'h170, 9'h080, 9'h099, 9'h1A0};
        run_frame(1'b1, 1'b0, lat, d0, s0, srb);
        @(negedge clk);
        run_frame(1'b1, 1'b1, lat, d1, s1, srb);
        @(negedge clk);
        checks += 3;
        if (d0 !== 18'sd2304) begin failures++; $display("FAIL gap_free_data: got %0d want 2304", d0); end
        if (d1 !== 18'sd2304) begin failures++; $display("FAIL gapped_data: got %0d want 2304", d1); end
        if (s1 !== 1'b0) begin failures++; $display("FAIL gapped_sat: got %b want 0", s1); end
    endtask

    task automatic test_last_at_max;
        int lat, srb, extra; logic signed [17:0] d; logic s;
        fq = '{9'h080, 9'h080, 9'h080, 9'h080, 9'h080, 9'h080, 9'h080, 9'h080};
        run_frame(1'b1, 1'b0, lat, d, s, srb);
        checks += 2;
        if (d !== 18'sd16384) begin failures++; $display("FAIL lastmax_data: got %0d want 16384", d); end
        if (lat !== 2) begin failures++; $display("FAIL lastmax_latency: got %0d want 2", lat); end
        extra = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.m_valid) extra++;
        end
        checks++;
        if (extra !== 0) begin failures++; $display("FAIL lastmax_dup: m_valid seen %0d cycles want 0", extra); end
    endtask

    task automatic test_reset_mid_frame;
        int lat, srb; logic signed [17:0] d; logic s;
        for (int i = 0; i < 3; i++) send_beat(9'h080, 1'b0, 0);
        rst_n = 1'b0;
        #1;
        checks += 3;
        if (bus.s_ready !== 1'b0) begin failures++; $display("FAIL mid_rst_s_ready: got %b want 0", bus.s_ready); end
        if (bus.m_valid !== 1'b0) begin failures++; $display("FAIL mid_rst_m_valid: got %b want 0", bus.m_valid); end
        if (bus.m_data !== 18'sd0) begin failures++; $display("FAIL mid_rst_m_data: got %0d want 0", bus.m_data); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        fq = '{9'h080, 9'h080};
        run_frame(1'b1, 1'b0, lat, d, s, srb);
        checks += 2;
        if (d !== 18'sd4096) begin failures++; $display("FAIL mid_rst_data: got %0d want 4096", d); end
        if (s !== 1'b0) begin failures++; $display("FAIL mid_rst_sat: got %b want 0", s); end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_ones();
        test_two_terms();
        test_saturation();
        test_zero();
        test_backpressure();
        test_gaps();
        test_last_at_max();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lfp_e4m4_dot_accum.md
Name: lfp_e4m4_dot_accum

Overview:
- Streaming consumer of 9-bit E4M4 products from the LFP E3M4 multiplier array.
- Decodes each product to fixed point and accumulates a dot product over a frame of up to N_TERMS beats.
- Emits one saturated Q6.11 result per frame on a valid/ready output.
- Sits between the multiplier lanes and the Q6.11 LSTM gate adders, replacing the per-lane combinational E4M4-to-Q6.11 and add path with a sequential, handshaked one.

Parameters:
- N_TERMS, 8, maximum products per frame; frame closes on this count or on s_last.
- ACC_W, 26, internal accumulator width; must be >= 21 + clog2(N_TERMS).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- s_valid  in  1  input product valid.
- s_ready  out  1  block can accept a product.
- s_data  in  9  E4M4 product: [8] sign, [7:4] exponent, [3:0] mantissa.
- s_last  in  1  final product of frame, qualified by s_valid.
- m_valid  out  1  result valid.
- m_ready  in  1  downstream accepts result.
- m_data  out  18  signed Q6.11 result.
- m_sat  out  1  result was clipped, qualified by m_valid.

Behaviour:
- Reset (async, rst_n=0): s_ready=0, m_valid=0, m_data=0, m_sat=0, term counter=0, accumulator=0, FSM=ACC. s_ready rises on the first clk edge after rst_n deasserts.
- Handshakes: input beat accepted when s_valid & s_ready; result consumed when m_valid & m_ready. Once m_valid is high, m_data and m_sat are held stable until consumed.
- E4M4 decode, bias 8:
  - Exponent e=0 means zero (mantissa ignored, sign ignored; -0 = 0). No subnormals.
  - e in 1..15: magnitude = (16+m) << (e-1) in Q6.11 LSBs. 1.0 = 0_1000_0000 -> 2048.
  - Decoded term is exact, 21-bit signed; sign applied by two's complement.
- Pipeline:
  - Stage 1 registers the decoded term plus valid/last flags.
  - Stage 2 adds it into the ACC_W-bit signed accumulator. The first term of a frame loads rather than adds.
- Saturation: at frame close, the accumulator is clipped to [-131072, 131071]; m_sat=1 iff clipped. No wrap-around anywhere.
- FSM:
  - ACC: s_ready=1. A beat is the frame-closing beat when it is accepted with s_last=1 or when the counter reaches N_TERMS-1. After the closing beat: s_ready=0, go to FLUSH.
  - FLUSH: pipeline drains; the final sum is saturated into m_data; m_valid=1; go to OUT. Result latency: m_valid high 2 cycles after the closing beat's accepting edge.
  - OUT: hold the result until m_ready. On consume: m_valid=0, accumulator and counter cleared, s_ready=1 next cycle, go to ACC.
- No overlap: the next frame is never accepted while a result is pending. Throughput is 1 beat/cycle within a frame, plus 3 cycles of frame overhead when m_ready is held high.
- s_valid low within a frame creates a bubble; the accumulator is unchanged.
- s_last with the counter already at N_TERMS-1: single close, no duplicate result.
- s_data/s_last are ignored while s_ready=0.
- Counter width is clog2(N_TERMS); it never wraps because the frame closes first.
- rst_n asserted mid-frame or while in OUT: partial sum discarded, no result emitted, all state returns to reset values.

Decomposition:
- lfp_pkg:
  - E4M4 field widths (sign 1, exp 4, man 4), E4M4_BIAS=8.
  - Q6.11 width 18, frac bits 11, Q611_MAX=131071, Q611_MIN=-131072.
  - Decoded term width 21; FSM state enum {ACC, FLUSH, OUT}.
- One combinational sub-module: e4m4_to_q_dec (9-bit E4M4 in, 21-bit signed exact term out), reused by other consumers of multiplier output.

Test Plan:
- 8 beats of 0_1000_0000 (1.0), m_ready=1 -> m_data=16384, m_sat=0, m_valid 2 cycles after the 8th accepted beat.
- Beats 0_1000_1000 (+1.5 = 3072) and 1_0111_0000 (-0.5 = -1024) with s_last on the 2nd -> m_data=2048, s_ready low from the cycle after the 2nd beat until result consumed.
- 8 beats of 0_1111_1111 (507904 each) -> m_data=131071, m_sat=1; 8 beats of 1_1111_1111 -> m_data=-131072, m_sat=1.
- Zero handling: beats 1_0000_1010, 0_0000_0111, 0_1000_0000 with s_last -> m_data=2048.
- Backpressure: m_ready=0 for 5 cycles after m_valid -> m_data/m_sat stable, s_ready=0 throughout; consume -> s_ready=1 next cycle; random s_valid gaps give the same sums as gap-free stimulus.
- Reset mid-frame: 3 beats of 1.0, pulse rst_n low -> all outputs 0; a new frame of 2x 1.0 with s_last -> m_data=4096, no stale contribution.
